gpu_cmd_decoder: RTL and testbench

Byte-stream command front end for the graphics card's operation port. Accepts framed FILL/BLIT packets from a byte source (UART receiver or host FIFO), assembles operands, range-checks them, then drives the card's `X1/Y1/X2/Y2/start_fill/fill_value/start_blit/blit_x_width/blit_y_height` inputs. It paces issue against the card's `busy`. It is the initiator side of the operation interface the card responds to.

---
 rtl/gpu_cmd_decoder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_gpu_cmd_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_cmd_decoder.sv
// Byte-stream FILL/BLIT packet decoder that range-checks operands and issues
// start strobes to the graphics card, pacing each issue against the card's busy.
module gpu_cmd_decoder #(
  parameter int unsigned X_MAX = 319,
  parameter int unsigned Y_MAX = 199
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       gpu_busy,
  input  logic       gpu_error,
  output logic [8:0] X1,
  output logic [7:0] Y1,
  output logic [8:0] X2,
  output logic [7:0] Y2,
  output logic [8:0] blit_x_width,
  output logic [7:0] blit_y_height,
  output logic       fill_value,
  output logic       start_fill,
  output logic       start_blit,
  output logic       cmd_reject,
  output logic       err_sticky,
  output logic [7:0] cmd_count
);

  localparam logic [7:0] OpFill   = 8'h46;
  localparam logic [7:0] OpBlit   = 8'h42;
  localparam logic [8:0] XMax     = X_MAX[8:0];
  localparam logic [7:0] YMax     = Y_MAX[7:0];
  localparam logic [3:0] LastFill = 4'd6;
  localparam logic [3:0] LastBlit = 4'd8;

  typedef enum logic [2:0] {
    StIdle,
    StPayload,
    StCheck,
    StWaitIdle,
    StIssue,
    StArm,
    StWaitDone
  } state_e;

  state_e     state_q, state_d;
  logic       is_blit_q, is_blit_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hi_bad_q, hi_bad_d;

  // Shadow operands being assembled from the byte stream
  logic [8:0] sh_x1_q, sh_x1_d, sh_x2_q, sh_x2_d, sh_w_q, sh_w_d;
  logic [7:0] sh_y1_q, sh_y1_d, sh_y2_q, sh_y2_d, sh_h_q, sh_h_d;
  logic       sh_fv_q, sh_fv_d;

  // Operands presented to the card
  logic [8:0] x1_q, x1_d, x2_q, x2_d, w_q, w_d;
  logic [7:0] y1_q, y1_d, y2_q, y2_d, h_q, h_d;
  logic       fv_q, fv_d;

  logic       start_fill_q, start_fill_d;
  logic       start_blit_q, start_blit_d;
  logic       reject_q, reject_d;
  logic       err_q, err_d;
  logic [7:0] count_q, count_d;

  logic       accept;
  logic       last_byte;
  logic       x_bad, y_bad, blit_bad, pkt_bad;

  assign in_ready  = (state_q == StIdle) || (state_q == StPayload);
  assign accept    = in_valid && in_ready;
  assign last_byte = (cnt_q == (is_blit_q ? LastBlit : LastFill));

  assign x_bad    = (sh_x1_q > XMax) || (sh_x2_q > XMax);
  assign y_bad    = (sh_y1_q > YMax) || (sh_y2_q > YMax);
  assign blit_bad = is_blit_q &&
                    ((sh_w_q > XMax) || (sh_h_q > YMax) || (sh_w_q == 9'd0) || (sh_h_q == 8'd0));
  assign pkt_bad  = hi_bad_q || x_bad || y_bad || blit_bad;

  always_comb begin
    state_d      = state_q;
    is_blit_d    = is_blit_q;
    cnt_d        = cnt_q;
    hi_bad_d     = hi_bad_q;
    sh_x1_d      = sh_x1_q;
    sh_y1_d      = sh_y1_q;
    sh_x2_d      = sh_x2_q;
    sh_y2_d      = sh_y2_q;
    sh_w_d       = sh_w_q;
    sh_h_d       = sh_h_q;
    sh_fv_d      = sh_fv_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    x2_d         = x2_q;
    y2_d         = y2_q;
    w_d          = w_q;
    h_d          = h_q;
    fv_d         = fv_q;
    start_fill_d = 1'b0;
    start_blit_d = 1'b0;
    reject_d     = 1'b0;
    err_d        = err_q;
    count_d      = count_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if ((in_data == OpFill) || (in_data == OpBlit)) begin
            is_blit_d = (in_data == OpBlit);
            cnt_d     = 4'd0;
            hi_bad_d  = 1'b0;
            state_d   = StPayload;
          end else begin
            // Unknown opcode is dropped so the stream can resynchronise
            reject_d = 1'b1;
          end
        end
      end

      StPayload: begin
        if (accept) begin
          cnt_d = cnt_q + 4'd1;
          case (cnt_q)
            4'd0: begin
              sh_x1_d[8] = in_data[0];
              hi_bad_d   = hi_bad_q || (|in_data[7:1]);
            end
            4'd1: sh_x1_d[7:0] = in_data;
            4'd2: sh_y1_d = in_data;
            4'd3: begin
              sh_x2_d[8] = in_data[0];
              hi_bad_d   = hi_bad_q || (|in_data[7:1]);
            end
            4'd4: sh_x2_d[7:0] = in_data;
            4'd5: sh_y2_d = in_data;
            4'd6: begin
              if (is_blit_q) begin
                sh_w_d[8] = in_data[0];
                hi_bad_d  = hi_bad_q || (|in_data[7:1]);
              end else begin
                sh_fv_d = in_data[0];
              end
            end
            4'd7: sh_w_d[7:0] = in_data;
            4'd8: sh_h_d = in_data;
            default: ;
          endcase
          if (last_byte) state_d = StCheck;
        end
      end

      StCheck: begin
        if (pkt_bad) begin
          reject_d = 1'b1;
          state_d  = StIdle;
        end else begin
          state_d = StWaitIdle;
        end
      end

      StWaitIdle: begin
        if (!gpu_busy) begin
          x1_d = sh_x1_q;
          y1_d = sh_y1_q;
          x2_d = sh_x2_q;
          y2_d = sh_y2_q;
          if (is_blit_q) begin
            w_d          = sh_w_q;
            h_d          = sh_h_q;
            start_blit_d = 1'b1;
          end else begin
            fv_d         = sh_fv_q;
            start_fill_d = 1'b1;
          end
          count_d = count_q + 8'd1;
          state_d = StIssue;
        end
      end

      StIssue: state_d = StArm;

      // The card raises busy only after seeing start, so busy is not sampled here
      StArm: begin
        if (gpu_error) err_d = 1'b1;
        state_d = StWaitDone;
      end

      StWaitDone: begin
        if (gpu_error) err_d = 1'b1;
        if (!gpu_busy) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      is_blit_q    <= 1'b0;
      cnt_q        <= 4'd0;
      hi_bad_q     <= 1'b0;
      sh_x1_q      <= 9'd0;
      sh_y1_q      <= 8'd0;
      sh_x2_q      <= 9'd0;
      sh_y2_q      <= 8'd0;
      sh_w_q       <= 9'd0;
      sh_h_q       <= 8'd0;
      sh_fv_q      <= 1'b0;
      x1_q         <= 9'd0;
      y1_q         <= 8'd0;
      x2_q         <= 9'd0;
      y2_q         <= 8'd0;
      w_q          <= 9'd0;
      h_q          <= 8'd0;
      fv_q         <= 1'b0;
      start_fill_q <= 1'b0;
      start_blit_q <= 1'b0;
      reject_q     <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      is_blit_q    <= is_blit_d;
      cnt_q        <= cnt_d;
      hi_bad_q     <= hi_bad_d;
      sh_x1_q      <= sh_x1_d;
      sh_y1_q      <= sh_y1_d;
      sh_x2_q      <= sh_x2_d;
      sh_y2_q      <= sh_y2_d;
      sh_w_q       <= sh_w_d;
      sh_h_q       <= sh_h_d;
      sh_fv_q      <= sh_fv_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      x2_q         <= x2_d;
      y2_q         <= y2_d;
      w_q          <= w_d;
      h_q          <= h_d;
      fv_q         <= fv_d;
      start_fill_q <= start_fill_d;
      start_blit_q <= start_blit_d;
      reject_q     <= reject_d;
      err_q        <= err_d;
      count_q      <= count_d;
    end
  end

  assign X1            = x1_q;
  assign Y1            = y1_q;
  assign X2            = x2_q;
  assign Y2            = y2_q;
  assign blit_x_width  = w_q;
  assign blit_y_height = h_q;
  assign fill_value    = fv_q;
  assign start_fill    = start_fill_q;
  assign start_blit    = start_blit_q;
  assign cmd_reject    = reject_q;
  assign err_sticky    = err_q;
  assign cmd_count     = count_q;

endmodule

// File: tb/tb_gpu_cmd_decoder.sv
// Directed bench for gpu_cmd_decoder with a small card model that holds busy
// for a few cycles after each start strobe.
module tb_gpu_cmd_decoder;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       gpu_busy;
  logic       gpu_error;
  logic [8:0] X1, X2, blit_x_width;
  logic [7:0] Y1, Y2, blit_y_height;
  logic       fill_value, start_fill, start_blit, cmd_reject, err_sticky;
  logic [7:0] cmd_count;

  int checks   = 0;
  int failures = 0;
  int card_cnt;
  logic busy_hold;
  int n_fill = 0;
  int n_blit = 0;

  gpu_cmd_decoder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .gpu_busy     (gpu_busy),
    .gpu_error    (gpu_error),
    .X1           (X1),
    .Y1           (Y1),
    .X2           (X2),
    .Y2           (Y2),
    .blit_x_width (blit_x_width),
    .blit_y_height(blit_y_height),
    .fill_value   (fill_value),
    .start_fill   (start_fill),
    .start_blit   (start_blit),
    .cmd_reject   (cmd_reject),
    .err_sticky   (err_sticky),
    .cmd_count    (cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Card model: busy for 4 cycles starting the cycle after a start strobe
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) card_cnt <= 0;
    else if (start_fill || start_blit) card_cnt <= 4;
    else if (card_cnt != 0) card_cnt <= card_cnt - 1;
  end
  assign gpu_busy = (card_cnt != 0) || busy_hold;

  always @(posedge clk) begin
    if (start_fill) n_fill <= n_fill + 1;
    if (start_blit) n_blit <= n_blit + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=in_ready_low expected=in_ready_high");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b [10], input int n);
    for (int i = 0; i < n; i++) send_byte(b[i]);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $error("FAIL ready_timeout observed=in_ready_low expected=in_ready_high");
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    gpu_error = 1'b0;
    busy_hold = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_x1", X1, 0);
    chk("rst_count", cmd_count, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_pulses", {start_fill, start_blit, cmd_reject}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);

    // FILL 10,5 -> 20,15 val 1; strobe three cycles after the last byte
    send_pkt('{8'h46, 8'h00, 8'h0A, 8'h05, 8'h00, 8'h14, 8'h0F, 8'h01, 8'h00, 8'h00}, 8);
    chk("fill_lat1", start_fill, 0);
    @(negedge clk);
    chk("fill_lat2", start_fill, 0);
    @(negedge clk);
    chk("fill_strobe", start_fill, 1);
    chk("fill_no_blit", start_blit, 0);
    chk("fill_count", cmd_count, 1);
    chk("fill_x1", X1, 10);
    chk("fill_y1", Y1, 5);
    chk("fill_x2", X2, 20);
    chk("fill_y2", Y2, 15);
    chk("fill_val", fill_value, 1);
    @(negedge clk);
    chk("fill_one_cycle", start_fill, 0);
    wait_ready();
    chk("fill_n", n_fill, 1);

    // BLIT x1=256, w=16, h=8
    send_pkt('{8'h42, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h08}, 10);
    repeat (2) @(negedge clk);
    chk("blit_strobe", start_blit, 1);
    chk("blit_no_fill", start_fill, 0);
    chk("blit_x1", X1, 256);
    chk("blit_y1", Y1, 0);
    chk("blit_x2", X2, 0);
    chk("blit_w", blit_x_width, 16);
    chk("blit_h", blit_y_height, 8);
    chk("blit_val_kept", fill_value, 1);
    chk("blit_count", cmd_count, 2);
    wait_ready();
    chk("blit_n", n_blit, 1);

    // FILL with x2=320 is out of range
    send_pkt('{8'h46, 8'h00, 8'h0A, 8'h05, 8'h01, 8'h40, 8'h0F, 8'h01, 8'h00, 8'h00}, 8);
    chk("rng_rej_early", cmd_reject, 0);
    @(negedge clk);
    chk("rng_reject", cmd_reject, 1);
    @(negedge clk);
    chk("rng_rej_width", cmd_reject, 0);
    chk("rng_ready", in_ready, 1);
    chk("rng_x1_kept", X1, 256);
    chk("rng_count", cmd_count, 2);

    // BLIT with zero width
    send_pkt('{8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08}, 10);
    @(negedge clk);
    chk("w0_reject", cmd_reject, 1);

    // FILL with a stray high bit in x1_hi
    @(negedge clk);
    send_pkt('{8'h46, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00}, 8);
    @(negedge clk);
    chk("hi_reject", cmd_reject, 1);
    @(negedge clk);
    chk("rej_no_strobe", n_fill + n_blit, 2);

    // Error while idle is not in flight
    gpu_error = 1'b1;
    @(negedge clk);
    gpu_error = 1'b0;
    chk("idle_err", err_sticky, 0);

    // Unknown opcode then a valid FILL
    send_byte(8'h7E);
    chk("unk_reject", cmd_reject, 1);
    chk("unk_ready", in_ready, 1);
    send_pkt('{8'h46, 8'h00, 8'h01, 8'h02, 8'h00, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00}, 8);
    repeat (2) @(negedge clk);
    chk("resync_strobe", start_fill, 1);
    chk("resync_x1", X1, 1);
    chk("resync_y2", Y2, 4);
    chk("resync_val", fill_value, 0);
    chk("resync_count", cmd_count, 3);
    repeat (2) @(negedge clk);
    gpu_error = 1'b1;
    @(negedge clk);
    gpu_error = 1'b0;
    chk("err_set", err_sticky, 1);
    wait_ready();
    chk("err_hold", err_sticky, 1);

    // Packet streamed while the card holds busy; x1=319,y1=199 are legal maxima
    busy_hold = 1'b1;
    send_pkt('{8'h46, 8'h01, 8'h3F, 8'hC7, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00}, 8);
    chk("hold_ready_low", in_ready, 0);
    repeat (10) @(negedge clk);
    chk("hold_ready_low2", in_ready, 0);
    chk("hold_x1_kept", X1, 1);
    chk("hold_no_strobe", start_fill, 0);
    repeat (38) @(negedge clk);
    busy_hold = 1'b0;
    @(negedge clk);
    chk("hold_strobe", start_fill, 1);
    chk("hold_x1", X1, 319);
    chk("hold_y1", Y1, 199);
    chk("hold_count", cmd_count, 4);
    wait_ready();

    // Reset in the middle of a packet
    send_pkt('{8'h46, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_err", err_sticky, 0);
    chk("mid_rst_count", cmd_count, 0);
    chk("mid_rst_x1", X1, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", in_ready, 1);
    repeat (5) @(negedge clk);
    chk("mid_rst_no_strobe", n_fill, 3);
    send_pkt('{8'h46, 8'h00, 8'h07, 8'h00, 8'h00, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00}, 8);
    repeat (2) @(negedge clk);
    chk("post_rst_strobe", start_fill, 1);
    chk("post_rst_x1", X1, 7);
    chk("post_rst_x2", X2, 8);
    chk("post_rst_count", cmd_count, 1);
    wait_ready();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
